// File: rtl/blake_msg_padder.sv
// BLAKE-256 message padder: turns a big-endian halfword stream into padded 32-halfword
// blocks on the core's init/load interface, with per-block bit counter and block handshake.
module blake_msg_padder #(
    parameter int INIT_GAP = 2,
    parameter int LEN_W    = 64
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        msg_start,
    input  logic        in_valid,
    output logic        in_ready,
    input  logic [15:0] in_data,
    input  logic [1:0]  in_nbytes,
    input  logic        in_last,
    output logic        out_init,
    output logic        out_load,
    output logic [15:0] out_data,
    input  logic        blk_ack,
    output logic [63:0] blk_counter,
    output logic        blk_final,
    output logic        msg_done,
    output logic        busy,
    output logic        err
);

    typedef enum logic [2:0] {
        IDLE,
        INIT,
        DATA,
        PAD,
        LEN,
        WAIT_ACK
    } state_t;

    state_t           state_q, state_d;
    logic [5:0]       w_q, w_d;
    logic [3:0]       gap_q, gap_d;
    logic [LEN_W-1:0] len_q, len_d;
    logic             pad_q, pad_d;
    logic             ended_q, ended_d;
    logic             out_init_q, out_init_d;
    logic             out_load_q, out_load_d;
    logic [15:0]      out_data_q, out_data_d;
    logic [63:0]      blk_counter_q, blk_counter_d;
    logic             blk_final_q, blk_final_d;
    logic             msg_done_q, msg_done_d;
    logic             err_q, err_d;

    logic [1:0]       nb;
    logic             last_eff;
    logic [5:0]       w_next;
    logic [LEN_W:0]   len_sum;
    logic [63:0]      len_ext;

    // A short word without in_last is still closed out as the final word.
    assign nb       = in_nbytes[1] ? 2'd2 : {1'b0, in_nbytes[0]};
    assign last_eff = in_last | ~in_nbytes[1];
    assign w_next   = (nb == 2'd0) ? w_q : w_q + 6'd1;
    assign len_sum  = {1'b0, len_q} + {{(LEN_W-4){1'b0}}, nb, 3'b000};
    assign len_ext  = 64'(len_q);

    always_comb begin
        state_d       = state_q;
        w_d           = w_q;
        gap_d         = gap_q;
        len_d         = len_q;
        pad_d         = pad_q;
        ended_d       = ended_q;
        out_init_d    = 1'b0;
        out_load_d    = 1'b0;
        out_data_d    = 16'h0000;
        blk_counter_d = blk_counter_q;
        blk_final_d   = blk_final_q;
        msg_done_d    = 1'b0;
        err_d         = err_q;

        if (msg_start && state_q != IDLE) begin
            err_d = 1'b1;
        end

        case (state_q)
            IDLE: begin
                if (msg_start) begin
                    out_init_d    = 1'b1;
                    len_d         = '0;
                    err_d         = 1'b0;
                    pad_d         = 1'b0;
                    ended_d       = 1'b0;
                    w_d           = 6'd0;
                    gap_d         = 4'd0;
                    blk_counter_d = 64'd0;
                    blk_final_d   = 1'b0;
                    state_d       = INIT;
                end
            end
            INIT: begin
                if (gap_q == 4'(INIT_GAP - 1)) begin
                    w_d     = 6'd0;
                    state_d = DATA;
                end else begin
                    gap_d = gap_q + 4'd1;
                end
            end
            DATA: begin
                if (in_valid) begin
                    len_d = len_sum[LEN_W-1:0];
                    w_d   = w_next;
                    if (len_sum[LEN_W] || (!in_last && !in_nbytes[1])) begin
                        err_d = 1'b1;
                    end
                    if (nb != 2'd0) begin
                        blk_counter_d = 64'(len_sum[LEN_W-1:0]);
                        out_load_d    = 1'b1;
                        out_data_d    = in_data;
                    end
                    if (!last_eff) begin
                        if (w_q == 6'd31) begin
                            state_d = WAIT_ACK;
                        end
                    end else begin
                        ended_d = 1'b1;
                        pad_d   = (nb != 2'd1);
                        if (nb == 2'd1) begin
                            out_data_d = {in_data[15:8], (w_q == 6'd27) ? 8'h81 : 8'h80};
                        end
                        // Pad byte landing on byte 55 merges with the 0x01 marker.
                        if (nb == 2'd1 && w_q == 6'd27) begin
                            blk_final_d = 1'b1;
                            state_d     = LEN;
                        end else if (w_next == 6'd32) begin
                            state_d = WAIT_ACK;
                        end else begin
                            blk_final_d = (w_next < 6'd28);
                            state_d     = PAD;
                        end
                    end
                end
            end
            PAD: begin
                out_load_d = 1'b1;
                pad_d      = 1'b0;
                w_d        = w_q + 6'd1;
                if (w_q == 6'd27) begin
                    out_data_d = {pad_q ? 8'h80 : 8'h00, 8'h01};
                    state_d    = LEN;
                end else begin
                    out_data_d = pad_q ? 16'h8000 : 16'h0000;
                    if (w_q == 6'd31) begin
                        state_d = WAIT_ACK;
                    end
                end
            end
            LEN: begin
                out_load_d = 1'b1;
                w_d        = w_q + 6'd1;
                case (w_q[1:0])
                    2'd0:    out_data_d = len_ext[63:48];
                    2'd1:    out_data_d = len_ext[47:32];
                    2'd2:    out_data_d = len_ext[31:16];
                    default: out_data_d = len_ext[15:0];
                endcase
                if (w_q == 6'd31) begin
                    state_d = WAIT_ACK;
                end
            end
            WAIT_ACK: begin
                if (blk_ack) begin
                    w_d           = 6'd0;
                    blk_counter_d = 64'd0;
                    if (blk_final_q) begin
                        msg_done_d  = 1'b1;
                        blk_final_d = 1'b0;
                        state_d     = IDLE;
                    end else if (ended_q) begin
                        blk_final_d = 1'b1;
                        state_d     = PAD;
                    end else begin
                        state_d = DATA;
                    end
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q       <= IDLE;
            w_q           <= 6'd0;
            gap_q         <= 4'd0;
            len_q         <= '0;
            pad_q         <= 1'b0;
            ended_q       <= 1'b0;
            out_init_q    <= 1'b0;
            out_load_q    <= 1'b0;
            out_data_q    <= 16'h0000;
            blk_counter_q <= 64'd0;
            blk_final_q   <= 1'b0;
            msg_done_q    <= 1'b0;
            err_q         <= 1'b0;
        end else begin
            state_q       <= state_d;
            w_q           <= w_d;
            gap_q         <= gap_d;
            len_q         <= len_d;
            pad_q         <= pad_d;
            ended_q       <= ended_d;
            out_init_q    <= out_init_d;
            out_load_q    <= out_load_d;
            out_data_q    <= out_data_d;
            blk_counter_q <= blk_counter_d;
            blk_final_q   <= blk_final_d;
            msg_done_q    <= msg_done_d;
            err_q         <= err_d;
        end
    end

    assign in_ready    = (state_q == DATA);
    assign busy        = (state_q != IDLE);
    assign out_init    = out_init_q;
    assign out_load    = out_load_q;
    assign out_data    = out_data_q;
    assign blk_counter = blk_counter_q;
    assign blk_final   = blk_final_q;
    assign msg_done    = msg_done_q;
    assign err         = err_q;

endmodule

// File: tb/tb_blake_msg_padder.sv
// Self-checking bench for blake_msg_padder: random and corner-case messages compared
// against a byte-level BLAKE-256 padding model.
module tb_blake_msg_padder;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        msg_start = 1'b0;
    logic        in_valid = 1'b0;
    logic        in_ready;
    logic [15:0] in_data = 16'h0000;
    logic [1:0]  in_nbytes = 2'd0;
    logic        in_last = 1'b0;
    logic        out_init;
    logic        out_load;
    logic [15:0] out_data;
    logic        blk_ack = 1'b0;
    logic [63:0] blk_counter;
    logic        blk_final;
    logic        msg_done;
    logic        busy;
    logic        err;

    logic [7:0]  msgBytes[$];
    logic [7:0]  expBytes[$];
    int          checkCount = 0;
    int          passCount = 0;

    blake_msg_padder #(.INIT_GAP(2), .LEN_W(64)) dut (
        .clk(clk), .rst_n(rst_n), .msg_start(msg_start),
        .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data),
        .in_nbytes(in_nbytes), .in_last(in_last),
        .out_init(out_init), .out_load(out_load), .out_data(out_data),
        .blk_ack(blk_ack), .blk_counter(blk_counter), .blk_final(blk_final),
        .msg_done(msg_done), .busy(busy), .err(err)
    );

    always #5 clk = ~clk;

    initial begin
        #900000;
        $display("[TB] FAIL watchdog: simulation did not finish in time");
        $fatal(1, "[TB] watchdog expired");
    end

    task automatic checkOutput(input string tag, input logic [63:0] actual, input logic [63:0] expected);
        checkCount++;
        if (actual === expected) passCount++;
        else $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", tag, actual, expected);
    endtask

    task automatic fillRandom(input int msgLen);
        msgBytes = {};
        for (int i = 0; i < msgLen; i++) msgBytes.push_back(8'($urandom));
    endtask

    // Padded image: message, 0x80, zeros, 0x01 at byte P-9, 64-bit bit length at the end.
    task automatic buildModel(input int msgLen);
        int padLen;
        longint unsigned bits;
        padLen = ((msgLen + 9 + 63) / 64) * 64;
        expBytes = {};
        for (int i = 0; i < padLen; i++) expBytes.push_back(8'h00);
        for (int i = 0; i < msgLen; i++) expBytes[i] = msgBytes[i];
        expBytes[msgLen] = expBytes[msgLen] | 8'h80;
        expBytes[padLen-9] = expBytes[padLen-9] | 8'h01;
        bits = longint'(msgLen) * 8;
        for (int k = 0; k < 8; k++) expBytes[padLen-8+k] = 8'(bits >> (56 - 8*k));
    endtask

    task automatic startMessage(input string tag);
        @(negedge clk);
        msg_start = 1'b1;
        @(negedge clk);
        msg_start = 1'b0;
        checkOutput({tag, "_init"}, 64'(out_init), 64'd1);
        checkOutput({tag, "_err_clear"}, 64'(err), 64'd0);
        @(negedge clk);
        checkOutput({tag, "_init_pulse"}, 64'(out_init), 64'd0);
    endtask

    // endMode: 0 = last data word flagged last, 1 = extra empty last word, 2 = odd tail without in_last
    task automatic applyStimulus(input int msgLen, input int endMode, input string tag);
        logic [15:0] wd[$];
        logic [1:0]  wn[$];
        logic        wl[$];
        int          budget;
        for (int k = 0; k < msgLen / 2; k++) begin
            wd.push_back({msgBytes[2*k], msgBytes[2*k+1]});
            wn.push_back(2'd2);
            wl.push_back(1'b0);
        end
        if (msgLen % 2 == 1) begin
            wd.push_back({msgBytes[msgLen-1], 8'($urandom)});
            wn.push_back(2'd1);
            wl.push_back(endMode != 2);
        end else if (msgLen == 0 || endMode == 1) begin
            wd.push_back(16'($urandom));
            wn.push_back(2'd0);
            wl.push_back(1'b1);
        end else begin
            wl[wl.size()-1] = 1'b1;
        end
        foreach (wd[i]) begin
            if ($urandom_range(0, 3) == 0) begin
                in_valid = 1'b0;
                @(negedge clk);
            end
            in_valid  = 1'b1;
            in_data   = wd[i];
            in_nbytes = wn[i];
            in_last   = wl[i];
            budget = 0;
            while (!in_ready && budget < 500) begin
                @(negedge clk);
                budget++;
            end
            if (!in_ready) begin
                checkOutput({tag, "_accept_timeout"}, 64'd0, 64'd1);
                in_valid = 1'b0;
                return;
            end
            @(negedge clk);
        end
        in_valid  = 1'b0;
        in_last   = 1'b0;
        in_nbytes = 2'd0;
    endtask

    task automatic collectBlocks(input int msgLen, input int holdCycles, input string tag);
        int nBlocks;
        int budget;
        int noisy;
        longint unsigned expCnt;
        nBlocks = expBytes.size() / 64;
        for (int b = 0; b < nBlocks; b++) begin
            for (int h = 0; h < 32; h++) begin
                budget = 0;
                @(negedge clk);
                while (!out_load && budget < 300) begin
                    @(negedge clk);
                    budget++;
                end
                if (!out_load) begin
                    checkOutput($sformatf("%s_b%0d_load_timeout", tag, b), 64'd0, 64'd1);
                    return;
                end
                checkOutput($sformatf("%s_b%0d_hw%0d", tag, b, h), 64'(out_data),
                            64'({expBytes[b*64+2*h], expBytes[b*64+2*h+1]}));
            end
            expCnt = (b*64 < msgLen) ? longint'(((msgLen < b*64+64) ? msgLen : b*64+64) * 8) : 0;
            checkOutput($sformatf("%s_b%0d_counter", tag, b), blk_counter, expCnt);
            checkOutput($sformatf("%s_b%0d_final", tag, b), 64'(blk_final), 64'(b == nBlocks-1));
            noisy = 0;
            for (int c = 0; c < holdCycles; c++) begin
                @(negedge clk);
                if (out_load || in_ready || !busy) noisy++;
            end
            if (holdCycles > 0) checkOutput($sformatf("%s_b%0d_hold", tag, b), 64'(noisy), 64'd0);
            blk_ack = 1'b1;
            @(negedge clk);
            blk_ack = 1'b0;
            if (b == nBlocks-1) begin
                checkOutput({tag, "_done"}, 64'(msg_done), 64'd1);
                checkOutput({tag, "_idle"}, 64'(busy), 64'd0);
                @(negedge clk);
                checkOutput({tag, "_done_pulse"}, 64'(msg_done), 64'd0);
            end else begin
                checkOutput($sformatf("%s_b%0d_no_done", tag, b), 64'(msg_done), 64'd0);
            end
        end
    endtask

    task automatic runMessage(input string tag, input int msgLen, input int endMode, input int hold);
        buildModel(msgLen);
        startMessage(tag);
        fork
            applyStimulus(msgLen, endMode, tag);
            collectBlocks(msgLen, hold, tag);
        join
        checkOutput({tag, "_err"}, 64'(err), 64'((endMode == 2 && msgLen % 2 == 1) ? 1 : 0));
    endtask

    task automatic checkAllZero(input string tag);
        checkOutput({tag, "_outputs"},
                    64'({in_ready, out_init, out_load, out_data, blk_final, msg_done, busy, err}), 64'd0);
        checkOutput({tag, "_counter"}, blk_counter, 64'd0);
    endtask

    initial begin
        int loads;
        int budget;
        repeat (3) @(negedge clk);
        checkAllZero("reset");
        rst_n = 1'b1;

        msgBytes = {8'h61, 8'h62, 8'h63};
        runMessage("abc", 3, 0, 1);
        msgBytes = {};
        runMessage("empty", 0, 1, 0);
        fillRandom(55); runMessage("len55", 55, 0, 2);
        fillRandom(56); runMessage("len56", 56, 0, 0);
        fillRandom(56); runMessage("len56z", 56, 1, 1);
        fillRandom(64); runMessage("len64", 64, 0, 3);
        fillRandom(7);  runMessage("short", 7, 2, 0);

        for (int i = 0; i < 8; i++) begin
            int len;
            len = $urandom_range(0, 150);
            fillRandom(len);
            runMessage($sformatf("rand%0d", i), len, $urandom_range(0, 2), $urandom_range(0, 4));
        end

        fillRandom(10);
        runMessage("withhold", 10, 0, 100);

        // Asynchronous reset while the padder is in the middle of a block.
        fillRandom(3);
        startMessage("rst");
        loads = 0;
        fork
            applyStimulus(3, 0, "rst");
            begin
                budget = 0;
                while (loads < 5 && budget < 300) begin
                    @(negedge clk);
                    if (out_load) loads++;
                    budget++;
                end
            end
        join
        checkOutput("rst_loads_seen", 64'(loads), 64'd5);
        rst_n = 1'b0;
        #1;
        checkAllZero("rst_mid");
        @(negedge clk);
        rst_n = 1'b1;

        startMessage("busy");
        msg_start = 1'b1;
        @(negedge clk);
        msg_start = 1'b0;
        checkOutput("busy_err", 64'(err), 64'd1);
        checkOutput("busy_still", 64'(busy), 64'd1);
        checkOutput("busy_no_init", 64'(out_init), 64'd0);
        rst_n = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);

        $display("%0d/%0d checks passed", passCount, checkCount);
        $finish;
    end

endmodule
